// File: rtl/ast_dma_mc_if.sv
// Configuration write bus plus memory/FIFO-side outputs of the multi-channel tensor DMA.
// The DMA uses the slave modport; whoever programs and observes it uses master.
interface ast_dma_mc_if #(
    parameter int DATAWIDTH = 8,
    parameter int NCH       = 2
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic                 write;
    logic [DATAWIDTH-1:0] data_in;
    logic [2:0]           select;
    logic [CHW-1:0]       chan;
    logic [DATAWIDTH-1:0] address_out;
    logic                 rW_out;
    logic [DATAWIDTH-1:0] depth_out;
    logic [DATAWIDTH-1:0] width_out;
    logic                 tensor_ren;
    logic                 tensor_wen;
    logic [1:0]           set;
    logic [CHW-1:0]       active_ch;
    logic                 busy;
    logic [NCH-1:0]       finished_transfer;
    logic [NCH-1:0]       error;

    modport slave (
        input  write, data_in, select, chan,
        output address_out, rW_out, depth_out, width_out, tensor_ren, tensor_wen,
               set, active_ch, busy, finished_transfer, error
    );

    modport master (
        output write, data_in, select, chan,
        input  address_out, rW_out, depth_out, width_out, tensor_ren, tensor_wen,
               set, active_ch, busy, finished_transfer, error
    );
endinterface

// File: rtl/ast_dma_mc.sv
// Multi-channel 2-D tensor DMA: per-channel config registers, a round-robin arbiter and
// one shared address generator walking cols x rows with a row pitch.
module ast_dma_mc #(
    parameter int DATAWIDTH = 8,
    parameter int NCH       = 2,
    parameter int RD_LAT    = 2
) (
    input  logic        clk,
    input  logic        rst,
    ast_dma_mc_if.slave bus
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_TRANSFER, S_FINISH} state_t;
    typedef logic [DATAWIDTH-1:0] word_t;

    localparam word_t      ONE       = word_t'(1);
    localparam logic [1:0] SET_X     = 2'd2;
    localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

    state_t         r_state, w_next_state;
    word_t          r_cols  [NCH];
    word_t          r_rows  [NCH];
    word_t          r_base  [NCH];
    word_t          r_pitch [NCH];
    logic [1:0]     r_set   [NCH];
    logic [NCH-1:0] r_start, r_abort, r_done, r_err;
    logic [CHW-1:0] r_active, r_last;
    word_t          r_addr, r_col, r_row;
    logic [1:0]     r_wait;
    logic           r_aborted;

    logic           w_chan_ok, w_running, w_is_active, w_cfg_locked, w_abort_req;
    logic           w_grant_vld, w_grant_bad;
    logic [CHW-1:0] w_grant;
    logic           w_is_read, w_wait_last, w_col_last, w_row_last, w_xfer_last;
    logic           w_ren, w_wen, w_idle;
    word_t          w_pitch_eff;

    assign w_idle       = (r_state == S_IDLE);
    assign w_chan_ok    = int'(bus.chan) < NCH;
    assign w_running    = (r_state == S_WAIT) || (r_state == S_TRANSFER);
    assign w_is_active  = (bus.chan == r_active) && !w_idle;
    assign w_cfg_locked = w_is_active && w_running;
    assign w_abort_req  = w_running &&
                          ((bus.write && bus.select == 3'd3 && bus.chan == r_active && bus.data_in[1])
                           || r_abort[r_active]);

    assign w_is_read   = (r_set[r_active] == SET_X);
    assign w_wait_last = (r_wait == WAIT_LAST);
    assign w_col_last  = (r_col == r_cols[r_active] - ONE);
    assign w_row_last  = (r_row == r_rows[r_active] - ONE);
    assign w_xfer_last = w_col_last && w_row_last;
    assign w_pitch_eff = (r_pitch[r_active] == '0) ? r_cols[r_active] : r_pitch[r_active];
    assign w_grant_bad = (r_cols[w_grant] == '0) || (r_rows[w_grant] == '0);

    // Search starts one past the last served channel so no requester can be starved.
    always_comb begin
        int idx;
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_grant_vld = 1'b0;
        w_grant     = '0;
        idx         = 0;
        for (int i = 1; i <= NCH; i++) begin
            idx = int'(r_last) + i;
            if (idx >= NCH) idx = idx - NCH;
            if (!w_grant_vld && r_start[CHW'(idx)]) begin
                w_grant_vld = 1'b1;
                w_grant     = CHW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next_state;
    end

    // Read strobes lead the address by one cycle to cover the FIFO read delay.
    always_comb begin
        w_next_state = r_state;
        w_ren        = 1'b0;
        w_wen        = 1'b0;
        unique case (r_state)
            S_IDLE: if (w_grant_vld && !w_grant_bad) w_next_state = S_WAIT;
            S_WAIT: begin
                w_ren = w_wait_last && w_is_read;
                if (w_abort_req)      w_next_state = S_FINISH;
                else if (w_wait_last) w_next_state = S_TRANSFER;
            end
            S_TRANSFER: begin
                w_ren = w_is_read && !w_xfer_last;
                w_wen = !w_is_read;
                if (w_abort_req || w_xfer_last) w_next_state = S_FINISH;
            end
            S_FINISH: w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the per-channel arrays are a handful of config registers, not a RAM,
            // so they are reset like any other flop.
            for (int c = 0; c < NCH; c++) begin
                r_cols[c]  <= '0;
                r_rows[c]  <= '0;
                r_base[c]  <= '0;
                r_pitch[c] <= '0;
                r_set[c]   <= '0;
            end
            r_start   <= '0;
            r_abort   <= '0;
            r_done    <= '0;
            r_err     <= '0;
            r_active  <= '0;
            r_last    <= CHW'(NCH - 1);
            r_addr    <= '0;
            r_col     <= '0;
            r_row     <= '0;
            r_wait    <= '0;
            r_aborted <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so the FSM updates below override a
            // same-cycle register write to the same bit.
            if (bus.write && w_chan_ok) begin
                if (bus.select == 3'd3) begin
                    if (!w_is_active) begin
                        r_start[bus.chan] <= bus.data_in[0];
                        if (bus.data_in[0]) begin
                            r_done[bus.chan] <= 1'b0;
                            r_err[bus.chan]  <= 1'b0;
                        end
                    end
                    r_abort[bus.chan] <= bus.data_in[1];
                end else if (!w_cfg_locked) begin
                    case (bus.select)
                        3'd0:    r_cols[bus.chan]  <= bus.data_in;
                        3'd1:    r_rows[bus.chan]  <= bus.data_in;
                        3'd2:    r_set[bus.chan]   <= bus.data_in[1:0];
                        3'd4:    r_base[bus.chan]  <= bus.data_in;
                        3'd5:    r_pitch[bus.chan] <= bus.data_in;
                        default: ;
                    endcase
                end
            end

            unique case (r_state)
                S_IDLE: if (w_grant_vld) begin
                    r_last <= w_grant;
                    if (w_grant_bad) begin
                        r_err[w_grant]   <= 1'b1;
                        r_start[w_grant] <= 1'b0;
                    end else begin
                        r_active  <= w_grant;
                        r_addr    <= r_base[w_grant];
                        r_col     <= '0;
                        r_row     <= '0;
                        r_wait    <= '0;
                        r_aborted <= 1'b0;
                    end
                end
                S_WAIT: begin
                    r_wait <= r_wait + 2'd1;
                    if (w_abort_req) r_aborted <= 1'b1;
                end
                S_TRANSFER: begin
                    if (w_abort_req) begin
                        r_aborted <= 1'b1;
                    end else if (!w_xfer_last) begin
                        if (w_col_last) begin
                            r_col  <= '0;
                            r_row  <= r_row + ONE;
                            r_addr <= r_addr + w_pitch_eff - r_cols[r_active] + ONE;
                        end else begin
                            r_col  <= r_col + ONE;
                            r_addr <= r_addr + ONE;
                        end
                    end
                end
                S_FINISH: begin
                    r_start[r_active] <= 1'b0;
                    r_abort[r_active] <= 1'b0;
                    if (r_aborted) r_err[r_active]  <= 1'b1;
                    else           r_done[r_active] <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.address_out       = w_idle ? '0 : r_addr;
    assign bus.depth_out         = w_idle ? '0 : r_cols[r_active];
    assign bus.width_out         = w_idle ? '0 : r_rows[r_active];
    assign bus.set               = w_idle ? 2'd0 : r_set[r_active];
    assign bus.active_ch         = w_idle ? '0 : r_active;
    assign bus.busy              = !w_idle;
    assign bus.tensor_ren        = w_ren;
    assign bus.rW_out            = w_ren;
    assign bus.tensor_wen        = w_wen;
    assign bus.finished_transfer = r_done;
    assign bus.error             = r_err;
endmodule

// File: tb/tb_ast_dma_mc.sv
// Self-checking bench for ast_dma_mc: directed vector table, multi-cycle corner sequences
// and random transfers checked against an address-list model.
module tb_ast_dma_mc;
    localparam int DW     = 8;
    localparam int NCH    = 4;
    localparam int RD_LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [7:0] exp_q[$];

    ast_dma_mc_if #(.DATAWIDTH(DW), .NCH(NCH)) bus ();

    ast_dma_mc #(.DATAWIDTH(DW), .NCH(NCH), .RD_LAT(RD_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]      ch;
        logic [7:0]      cols;
        logic [7:0]      rows;
        logic [7:0]      base;
        logic [7:0]      pitch;
        logic [1:0]      set_v;
        logic            exp_err;
        logic [3:0]      exp_n;
        logic [0:7][7:0] exp_addr;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cfg_write(input int ch, input logic [2:0] sel, input logic [7:0] d);
        bus.write   = 1'b1;
        bus.chan    = 2'(ch);
        bus.select  = sel;
        bus.data_in = d;
        @(negedge clk);
        bus.write   = 1'b0;
    endtask

    task automatic cfg_chan(input int ch, input logic [7:0] cols, input logic [7:0] rows,
                            input logic [7:0] base, input logic [7:0] pitch, input logic [1:0] sv);
        cfg_write(ch, 3'd0, cols);
        cfg_write(ch, 3'd1, rows);
        cfg_write(ch, 3'd2, {6'd0, sv});
        cfg_write(ch, 3'd4, base);
        cfg_write(ch, 3'd5, pitch);
    endtask

    task automatic wait_busy(input string name, input logic lvl);
        int w;
        w = 0;
        while (bus.busy !== lvl && w < 400) begin
            @(negedge clk);
            w++;
        end
        check(name, bus.busy, lvl);
    endtask

    // Model: row r, column c lives at base + r*pitch + c (pitch 0 means packed rows).
    task automatic model(input int cols, input int rows, input int base, input int pitch);
        int pe;
        pe = (pitch == 0) ? cols : pitch;
        exp_q.delete();
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < cols; c++)
                exp_q.push_back(8'((base + r * pe + c) % 256));
    endtask

    task automatic xfer(input string name, input int ch, input logic [7:0] cols,
                        input logic [7:0] rows, input logic [7:0] base, input logic [7:0] pitch,
                        input logic [1:0] sv, input bit exp_err);
        int         n, busy_cyc, strobe_bad;
        bit         rd, e_ren, e_wen;
        logic [7:0] a_q[$];
        logic       ren_q[$], wen_q[$], rw_q[$];
        n  = exp_q.size();
        rd = (sv == 2'd2);
        cfg_chan(ch, cols, rows, base, pitch, sv);
        cfg_write(ch, 3'd3, 8'h01);
        if (exp_err) begin
            busy_cyc = 0;
            repeat (6) begin
                @(negedge clk);
                if (bus.busy) busy_cyc++;
            end
            check({name, " busy_cycles"}, busy_cyc, 0);
            check({name, " error"}, bus.error[ch], 1'b1);
            check({name, " finished"}, bus.finished_transfer[ch], 1'b0);
            return;
        end
        wait_busy({name, " busy_rise"}, 1'b1);
        if (!bus.busy) return;
        check({name, " active_ch"}, bus.active_ch, ch);
        check({name, " depth_out"}, bus.depth_out, cols);
        check({name, " width_out"}, bus.width_out, rows);
        check({name, " set_out"}, bus.set, sv);
        while (bus.busy && a_q.size() < 300) begin
            a_q.push_back(bus.address_out);
            ren_q.push_back(bus.tensor_ren);
            wen_q.push_back(bus.tensor_wen);
            rw_q.push_back(bus.rW_out);
            @(negedge clk);
        end
        check({name, " busy_cycles"}, a_q.size(), RD_LAT + n + 1);
        for (int i = 0; i < n; i++)
            if (RD_LAT + i < a_q.size())
                check($sformatf("%s addr%0d", name, i), a_q[RD_LAT + i], exp_q[i]);
        strobe_bad = 0;
        for (int i = 0; i < a_q.size(); i++) begin
            e_ren = rd && (i >= RD_LAT - 1) && (i <= RD_LAT + n - 2);
            e_wen = !rd && (i >= RD_LAT) && (i <= RD_LAT + n - 1);
            if (ren_q[i] !== e_ren || rw_q[i] !== e_ren || wen_q[i] !== e_wen) strobe_bad++;
        end
        check({name, " strobe_cycles_wrong"}, strobe_bad, 0);
        check({name, " finished"}, bus.finished_transfer[ch], 1'b1);
        check({name, " error"}, bus.error[ch], 1'b0);
        check({name, " idle_address"}, bus.address_out, 8'h00);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.write   = 1'b0;
        bus.data_in = '0;
        bus.select  = '0;
        bus.chan    = '0;

        vecs[0] = '{ch:2'd0, cols:8'd3, rows:8'd2, base:8'h10, pitch:8'd0, set_v:2'd2, exp_err:1'b0,
                    exp_n:4'd6, exp_addr:{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h00, 8'h00}};
        vecs[1] = '{ch:2'd1, cols:8'd2, rows:8'd3, base:8'h20, pitch:8'd4, set_v:2'd0, exp_err:1'b0,
                    exp_n:4'd6, exp_addr:{8'h20, 8'h21, 8'h24, 8'h25, 8'h28, 8'h29, 8'h00, 8'h00}};
        vecs[2] = '{ch:2'd2, cols:8'd4, rows:8'd1, base:8'hFE, pitch:8'd0, set_v:2'd3, exp_err:1'b0,
                    exp_n:4'd4, exp_addr:{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[3] = '{ch:2'd3, cols:8'd2, rows:8'd0, base:8'h33, pitch:8'd0, set_v:2'd2, exp_err:1'b1,
                    exp_n:4'd0, exp_addr:64'd0};
        vecs[4] = '{ch:2'd1, cols:8'd0, rows:8'd3, base:8'h44, pitch:8'd0, set_v:2'd0, exp_err:1'b1,
                    exp_n:4'd0, exp_addr:64'd0};
        vecs[5] = '{ch:2'd0, cols:8'd1, rows:8'd1, base:8'h7F, pitch:8'd9, set_v:2'd1, exp_err:1'b0,
                    exp_n:4'd1, exp_addr:{8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[6] = '{ch:2'd3, cols:8'd2, rows:8'd2, base:8'hF0, pitch:8'h20, set_v:2'd2, exp_err:1'b0,
                    exp_n:4'd4, exp_addr:{8'hF0, 8'hF1, 8'h10, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00}};

        #1 rst = 1'b0;
        #1;
        check("reset address_out", bus.address_out, 8'h00);
        check("reset busy", bus.busy, 1'b0);
        check("reset strobes", {bus.tensor_ren, bus.tensor_wen, bus.rW_out}, 3'b000);
        check("reset flags", {bus.finished_transfer, bus.error}, 8'h00);
        check("reset active_ch", bus.active_ch, 2'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            exp_q.delete();
            for (int k = 0; k < int'(vecs[i].exp_n); k++) exp_q.push_back(vecs[i].exp_addr[k]);
            xfer($sformatf("vec%0d", i), int'(vecs[i].ch), vecs[i].cols, vecs[i].rows,
                 vecs[i].base, vecs[i].pitch, vecs[i].set_v, vecs[i].exp_err);
        end

        // ch0 and ch1 become pending together while ch3 runs; ch0 must win, then ch1.
        cfg_chan(0, 8'd2, 8'd1, 8'h30, 8'd0, 2'd0);
        cfg_chan(1, 8'd1, 8'd2, 8'h50, 8'd0, 2'd2);
        cfg_chan(3, 8'd8, 8'd4, 8'h80, 8'd0, 2'd1);
        cfg_write(3, 3'd3, 8'h01);
        wait_busy("arb ch3 busy_rise", 1'b1);
        cfg_write(1, 3'd3, 8'h01);
        cfg_write(0, 3'd3, 8'h01);
        cfg_write(3, 3'd3, 8'h01);
        wait_busy("arb ch3 busy_fall", 1'b0);
        check("arb ch3 finished", bus.finished_transfer[3], 1'b1);
        wait_busy("arb first busy_rise", 1'b1);
        check("arb first grant", bus.active_ch, 2'd0);
        wait_busy("arb first busy_fall", 1'b0);
        wait_busy("arb second busy_rise", 1'b1);
        check("arb second grant", bus.active_ch, 2'd1);
        wait_busy("arb second busy_fall", 1'b0);
        check("arb both finished", {bus.finished_transfer[1], bus.finished_transfer[0]}, 2'b11);
        begin
            int bc;
            bc = 0;
            repeat (10) begin
                @(negedge clk);
                if (bus.busy) bc++;
            end
            check("arb restart_while_active_ignored busy_cycles", bc, 0);
        end

        // Abort written on the third address.
        cfg_chan(2, 8'd4, 8'd2, 8'h40, 8'd0, 2'd0);
        cfg_write(2, 3'd3, 8'h01);
        wait_busy("abort busy_rise", 1'b1);
        repeat (RD_LAT + 2) @(negedge clk);
        check("abort third address", bus.address_out, 8'h42);
        cfg_write(2, 3'd3, 8'h02);
        check("abort finish busy", bus.busy, 1'b1);
        check("abort finish strobes", {bus.tensor_ren, bus.tensor_wen, bus.rW_out}, 3'b000);
        @(negedge clk);
        check("abort busy_after", bus.busy, 1'b0);
        check("abort error", bus.error[2], 1'b1);
        check("abort finished", bus.finished_transfer[2], 1'b0);

        for (int it = 0; it < 24; it++) begin
            int ch, cols, rows, base, pitch, sv;
            ch    = $urandom_range(0, NCH - 1);
            cols  = $urandom_range(0, 5);
            rows  = $urandom_range(0, 4);
            base  = $urandom_range(0, 255);
            pitch = $urandom_range(0, 9);
            sv    = $urandom_range(0, 3);
            model(cols, rows, base, pitch);
            xfer($sformatf("rnd%0d", it), ch, 8'(cols), 8'(rows), 8'(base), 8'(pitch), 2'(sv),
                 (cols == 0) || (rows == 0));
        end

        // Reset in the middle of a read transfer.
        cfg_chan(1, 8'd4, 8'd4, 8'h60, 8'd0, 2'd2);
        cfg_write(1, 3'd3, 8'h01);
        wait_busy("rst_mid busy_rise", 1'b1);
        repeat (RD_LAT + 2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_mid address_out", bus.address_out, 8'h00);
        check("rst_mid strobes", {bus.tensor_ren, bus.tensor_wen, bus.rW_out}, 3'b000);
        check("rst_mid busy", bus.busy, 1'b0);
        check("rst_mid depth_width", {bus.depth_out, bus.width_out}, 16'h0000);
        check("rst_mid set_active", {bus.set, bus.active_ch}, 4'h0);
        check("rst_mid flags", {bus.finished_transfer, bus.error}, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        begin
            int bc;
            bc = 0;
            repeat (8) begin
                @(negedge clk);
                if (bus.busy || bus.finished_transfer[1]) bc++;
            end
            check("rst_mid idle_after_release cycles", bc, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
